// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback path: address/data
// widths and the buffered MAC result entry.
package writeback_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// wb_fifo: synchronous FIFO holding MAC results until the write port is free.
// A full FIFO still takes a push in a cycle where the head is leaving, so a
// push and pop while full leave the occupancy unchanged.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally for power-of-two depths.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges the pipeline writeback and buffered MAC results
// onto the single register-file write port and tracks in-flight MAC
// destinations in a busy scoreboard for decode.
// Optional feature macro: WB_STARVE_GUARD_EN (forced FIFO drain after
// STARVE_LIMIT waiting cycles, signalled on pipe_stall).
import writeback_arbiter_pkg::*;

module writeback_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        pipe_valid,
  input  logic [4:0]                  pipe_rd,
  input  logic [31:0]                 pipe_data,
  input  logic                        mac_issue_valid,
  input  logic [4:0]                  mac_issue_rd,
  input  logic                        mac_valid,
  output logic                        mac_ready,
  input  logic [4:0]                  mac_rd,
  input  logic [31:0]                 mac_data,
  output logic                        rf_we,
  output logic [4:0]                  rf_rd,
  output logic [31:0]                 rf_wdata,
  output logic [31:0]                 busy_mask,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        pipe_stall
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  wb_entry_t   push_entry;
  wb_entry_t   head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        grant_pipe;
  logic        grant_fifo;
  logic        src_mac;
  logic        stall_now;
  logic [31:0] busy_next;

  assign push_entry = '{rd: mac_rd, data: mac_data};
  assign mac_ready  = !fifo_full;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WB_ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (mac_valid),
    .pop   (grant_fifo),
    .din   (push_entry),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef WB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          stall_q;

  assign stall_now  = stall_q;
  assign pipe_stall = stall_q;

  // Count cycles the FIFO head waits; raise a one-cycle stall when the limit is reached.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else if (fifo_empty || grant_fifo) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt + 1'b1;
      stall_q    <= (starve_cnt == CW'(STARVE_LIMIT - 1));
    end
  end
`else
  assign stall_now  = 1'b0;
  assign pipe_stall = 1'b0;
`endif

  assign grant_pipe = pipe_valid && !stall_now;
  assign grant_fifo = !grant_pipe && !fifo_empty;

  // Register the granted write so the register file sees it one cycle after the request.
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      src_mac  <= 1'b0;
    end else if (grant_pipe) begin
      rf_we    <= 1'b1;
      rf_rd    <= pipe_rd;
      rf_wdata <= pipe_data;
      src_mac  <= 1'b0;
    end else if (grant_fifo) begin
      rf_we    <= 1'b1;
      rf_rd    <= head.rd;
      rf_wdata <= head.data;
      src_mac  <= 1'b1;
    end else begin
      rf_we    <= 1'b0;
      src_mac  <= 1'b0;
    end
  end

  // Next scoreboard value: MAC commit clears first so a same-edge issue wins; x0 never busy.
  always_comb begin
    busy_next = busy_mask;
    if (rf_we && src_mac) begin
      busy_next[rf_rd] = 1'b0;
    end
    if (mac_issue_valid && (mac_issue_rd != 5'd0)) begin
      busy_next[mac_issue_rd] = 1'b1;
    end
  end

  // Scoreboard state exported to decode.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_mask <= '0;
    end else begin
      busy_mask <= busy_next;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random
// traffic compared each cycle against a queue-based behavioural model.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mac_issue_valid;
  logic [4:0]  mac_issue_rd;
  logic        mac_valid;
  logic        mac_ready;
  logic [4:0]  mac_rd;
  logic [31:0] mac_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
  logic [$clog2(DEPTH):0] fifo_count;
  logic        pipe_stall;

  int checks   = 0;
  int failures = 0;

  logic [36:0] m_q[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_src_mac;
  logic [31:0] m_busy;
  int          m_wait;
  logic        m_stall;
  int          stall_seen;

  writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock           (clock),
    .reset           (reset),
    .pipe_valid      (pipe_valid),
    .pipe_rd         (pipe_rd),
    .pipe_data       (pipe_data),
    .mac_issue_valid (mac_issue_valid),
    .mac_issue_rd    (mac_issue_rd),
    .mac_valid       (mac_valid),
    .mac_ready       (mac_ready),
    .mac_rd          (mac_rd),
    .mac_data        (mac_data),
    .rf_we           (rf_we),
    .rf_rd           (rf_rd),
    .rf_wdata        (rf_wdata),
    .busy_mask       (busy_mask),
    .fifo_count      (fifo_count),
    .pipe_stall      (pipe_stall)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Single comparison point: count it and report any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model state
  task automatic checkModel(input string tag);
    checkOutput({tag, ".rf_we"},      32'(rf_we),      32'(m_we));
    checkOutput({tag, ".rf_rd"},      32'(rf_rd),      32'(m_rd));
    checkOutput({tag, ".rf_wdata"},   rf_wdata,        m_data);
    checkOutput({tag, ".busy_mask"},  busy_mask,       m_busy);
    checkOutput({tag, ".fifo_count"}, 32'(fifo_count), 32'(m_q.size()));
    checkOutput({tag, ".mac_ready"},  32'(mac_ready),  32'(m_q.size() < DEPTH));
    checkOutput({tag, ".pipe_stall"}, 32'(pipe_stall), 32'(m_stall));
  endtask

  task automatic modelReset();
    m_q.delete();
    m_we      = 1'b0;
    m_rd      = '0;
    m_data    = '0;
    m_src_mac = 1'b0;
    m_busy    = '0;
    m_wait    = 0;
    m_stall   = 1'b0;
  endtask

  task automatic doReset(input string tag);
    reset           = 1'b1;
    pipe_valid      = 1'b0;
    pipe_rd         = '0;
    pipe_data       = '0;
    mac_issue_valid = 1'b0;
    mac_issue_rd    = '0;
    mac_valid       = 1'b0;
    mac_rd          = '0;
    mac_data        = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    modelReset();
    checkModel(tag);
  endtask

  // Drive one cycle of inputs, advance the model by the arbiter rules, then compare
  task automatic applyStimulus(input string tag,
                               input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                               input logic iv, input logic [4:0] ird,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
    bit          take_pipe;
    bit          take_fifo;
    bit          accept;
    bit          was_nonempty;
    logic [36:0] head;
    pipe_valid      = pv;
    pipe_rd         = prd;
    pipe_data       = pdata;
    mac_issue_valid = iv;
    mac_issue_rd    = ird;
    mac_valid       = mv;
    mac_rd          = mrd;
    mac_data        = mdata;
    take_pipe    = pv && !m_stall;
    take_fifo    = !take_pipe && (m_q.size() > 0);
    accept       = mv && ((m_q.size() < DEPTH) || take_fifo);
    was_nonempty = (m_q.size() > 0);
    @(posedge clock);
    #1;
    if (m_we && m_src_mac) m_busy[m_rd] = 1'b0;
    if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
    if (take_pipe) begin
      m_we = 1'b1; m_rd = prd; m_data = pdata; m_src_mac = 1'b0;
    end else if (take_fifo) begin
      head = m_q.pop_front();
      m_we = 1'b1; m_rd = head[36:32]; m_data = head[31:0]; m_src_mac = 1'b1;
    end else begin
      m_we = 1'b0; m_src_mac = 1'b0;
    end
    if (accept) m_q.push_back({mrd, mdata});
`ifdef WB_STARVE_GUARD_EN
    if (!was_nonempty || take_fifo) begin
      m_wait  = 0;
      m_stall = 1'b0;
    end else begin
      m_wait++;
      m_stall = (m_wait == LIMIT);
    end
`else
    if (was_nonempty) m_wait = 0;
`endif
    if (pipe_stall === 1'b1) stall_seen++;
    checkModel(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    stall_seen = 0;
    doReset("reset0");

    // Reset during traffic: three buffered results and busy bits 5,6,7
    for (int i = 0; i < 3; i++) begin
      applyStimulus("fill", 1, 5'd1, 32'h100 + i, 1, 5'(5 + i), 1, 5'(5 + i), 32'hA0 + i);
    end
    checkOutput("fill.busy", busy_mask, 32'h0000_00E0);
    doReset("midreset");
    checkOutput("midreset.count", 32'(fifo_count), 0);
    checkOutput("midreset.busy",  busy_mask, 0);
    checkOutput("midreset.we",    32'(rf_we), 0);
    checkOutput("midreset.ready", 32'(mac_ready), 1);

    // Pipe only
    applyStimulus("pipe", 1, 5'd3, 32'h1234, 0, 0, 0, 0, 0);
    checkOutput("pipe.we",   32'(rf_we), 1);
    checkOutput("pipe.rd",   32'(rf_rd), 3);
    checkOutput("pipe.data", rf_wdata, 32'h1234);
    idle("pipe_idle");
    checkOutput("pipe_idle.we", 32'(rf_we), 0);

    // MAC path with scoreboard
    applyStimulus("issue9", 0, 0, 0, 1, 5'd9, 0, 0, 0);
    applyStimulus("push9", 0, 0, 0, 0, 0, 1, 5'd9, 32'hFFFF_FFF0);
    checkOutput("push9.busy9", 32'(busy_mask[9]), 1);
    idle("pop9");
    checkOutput("pop9.we",    32'(rf_we), 1);
    checkOutput("pop9.data",  rf_wdata, 32'hFFFF_FFF0);
    checkOutput("pop9.busy9", 32'(busy_mask[9]), 1);
    idle("after9");
    checkOutput("after9.busy9", 32'(busy_mask[9]), 0);

    // Contention: pipe every cycle while offering five MAC results
    for (int i = 0; i < 6; i++) begin
      applyStimulus("contend", 1, 5'(i + 1), 32'h200 + i, 0, 0, (i < 5), 5'(16 + i), 32'hC00 + i);
    end
`ifndef WB_STARVE_GUARD_EN
    checkOutput("contend.ready", 32'(mac_ready), 0);
    checkOutput("contend.count", 32'(fifo_count), 4);
`endif

    // Full and simultaneous push/pop
    doReset("reset_full");
    for (int i = 0; i < 4; i++) begin
      applyStimulus("fill4", 1, 5'd2, 32'h300 + i, 0, 0, 1, 5'(20 + i), 32'hD00 + i);
    end
    applyStimulus("fullpp", 0, 0, 0, 0, 0, 1, 5'd24, 32'hD04);
    checkOutput("fullpp.count", 32'(fifo_count), 4);
    checkOutput("fullpp.ready", 32'(mac_ready), 0);
    for (int i = 0; i < 5; i++) idle("drain");

    // Same-edge set and clear on register 12
    applyStimulus("issue12", 0, 0, 0, 1, 5'd12, 0, 0, 0);
    applyStimulus("push12", 0, 0, 0, 0, 0, 1, 5'd12, 32'h12);
    idle("pop12");
    applyStimulus("reissue12", 0, 0, 0, 1, 5'd12, 0, 0, 0);
    checkOutput("reissue12.busy12", 32'(busy_mask[12]), 1);

    // Continuous pipe with one buffered head
    doReset("reset_starve");
    applyStimulus("starve_push", 1, 5'd4, 32'h400, 0, 0, 1, 5'd25, 32'hE00);
    for (int i = 0; i < 12; i++) applyStimulus("starve", 1, 5'd4, 32'h401 + i, 0, 0, 0, 0, 0);
`ifdef WB_STARVE_GUARD_EN
    checkOutput("starve.stall_seen", 32'(stall_seen), 1);
`else
    checkOutput("starve.stall_seen", 32'(stall_seen), 0);
    checkOutput("starve.count", 32'(fifo_count), 1);
`endif

    // Random traffic
    doReset("reset_rand");
    for (int i = 0; i < 600; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 9) < 5), 5'($urandom), $urandom,
                    ($urandom_range(0, 3) == 0), 5'($urandom),
                    ($urandom_range(0, 2) != 0), 5'($urandom), $urandom);
      if (i == 300) doReset("rand_midreset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
